// File: rtl/huffman_pkg.sv
// Shared types for the Huffman front end: symbol/count sizing, the frequency
// table type handed to tree_construct, and the histogram controller states.
package huffman_pkg;

    localparam int NUM_SYM = 128;
    localparam int CNT_W   = 16;
    localparam int DATA_W  = 8;

    typedef logic [CNT_W-1:0] count_t;
    typedef count_t [NUM_SYM-1:0] count_table_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        TREE
    } hist_state_t;

endpackage

// File: rtl/char_histogram_sat_incr.sv
// Saturating +1 for a count_t; sat is high when the input is already at
// full scale, in which case the value is passed through unchanged.
module sat_incr
    import huffman_pkg::*;
(
    input  count_t value,
    output count_t incr,
    output logic   sat
);

    // Hold at all-ones instead of wrapping.
    always_comb begin
        sat  = &value;
        incr = sat ? value : value + count_t'(1);
    end

endmodule

// File: rtl/char_histogram.sv
// Builds the 128-bin symbol frequency table from a byte stream, then hands
// it to tree_construct and keeps it frozen until the tree is finished.
//
//  state | meaning
//  IDLE  | table/flags held from previous stream; waiting for count_start
//  COUNT | accepting one byte per cycle into the table
//  TREE  | table frozen, build_tree_start held until build_tree_finish
module char_histogram
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              count_start,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_last,
    output logic              data_ready,
    input  logic              build_tree_finish,
    output logic              build_tree_start,
    output count_table_t      curr_count,
    output count_t            total_count,
    output logic              sat_flag,
    output logic              invalid_flag,
    output logic              empty_err
);

    hist_state_t state, state_next;

    logic                     accept;
    logic                     sym_ok;
    logic [6:0]               sym_idx;
    logic                     stream_empty;
    count_t                   bin_cur, bin_inc, tot_inc;
    logic                     bin_sat, tot_sat;

    assign accept  = (state == COUNT) && data_valid;
    assign sym_ok  = ~data_in[7];
    assign sym_idx = data_in[6:0];
    assign bin_cur = curr_count[sym_idx];

    // A valid symbol always leaves total_count non-zero (even when saturated),
    // so the stream is empty only if nothing was counted and this byte is dropped.
    assign stream_empty = (total_count == '0) && !sym_ok;

    sat_incr u_bin_incr (
        .value (bin_cur),
        .incr  (bin_inc),
        .sat   (bin_sat)
    );

    sat_incr u_total_incr (
        .value (total_count),
        .incr  (tot_inc),
        .sat   (tot_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next       = state;
        data_ready       = 1'b0;
        build_tree_start = 1'b0;
        case (state)
            IDLE: begin
                if (count_start) state_next = COUNT;
            end
            COUNT: begin
                data_ready = 1'b1;
                if (data_valid && data_last) state_next = stream_empty ? IDLE : TREE;
            end
            TREE: begin
                build_tree_start = 1'b1;
                if (build_tree_finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Table, running total and sticky flags; read-modify-write on the registered bin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curr_count   <= '0;
            total_count  <= '0;
            sat_flag     <= 1'b0;
            invalid_flag <= 1'b0;
            empty_err    <= 1'b0;
        end else if (state == IDLE && count_start) begin
            curr_count   <= '0;
            total_count  <= '0;
            sat_flag     <= 1'b0;
            invalid_flag <= 1'b0;
            empty_err    <= 1'b0;
        end else if (accept) begin
            if (sym_ok) begin
                curr_count[sym_idx] <= bin_inc;
                total_count         <= tot_inc;
                if (bin_sat || tot_sat) sat_flag <= 1'b1;
            end else begin
                invalid_flag <= 1'b1;
            end
            if (data_last && stream_empty) empty_err <= 1'b1;
        end
    end

endmodule
